// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
// Bundles the three requester ports (video = 0, CPU = 1, GPU = 2) and the
// single SDRAM controller request interface that sdram_arbiter shares.
//   req/we          : per-port request and write enable (3 bits each)
//   addr/wdata      : packed per-port fields, port n at [n*W +: W]
//   ack/rvalid      : per-port one-cycle pulses back to the requesters
//   rdata           : shared read data, qualified by rvalid
//   ctrl_*          : muxed request toward the controller and its responses
// Modports: slave = arbiter view, master = requester/controller environment.
// -----------------------------------------------------------------------------
interface sdram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          ack;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;

    logic                ctrl_req;
    logic                ctrl_we;
    logic [ADDR_W-1:0]   ctrl_addr;
    logic [DATA_W-1:0]   ctrl_wdata;
    logic                ctrl_ready;
    logic                ctrl_rvalid;
    logic [DATA_W-1:0]   ctrl_rdata;

    modport slave (
        input  req, we, addr, wdata, ctrl_ready, ctrl_rvalid, ctrl_rdata,
        output ack, rvalid, rdata, ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata
    );

    modport master (
        output req, we, addr, wdata, ctrl_ready, ctrl_rvalid, ctrl_rdata,
        input  ack, rvalid, rdata, ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller request interface between video scanout
// (port 0), CPU (port 1) and GPU (port 2), one transaction in flight.
// Video has fixed priority bounded by a starvation limit, CPU/GPU alternate
// round-robin, and a hold counter allows short same-port runs.
// Ports:
//   i_clk    : system clock, all logic on the rising edge
//   i_reset  : synchronous active-high reset
//   io_bus   : sdram_arbiter_if.slave (requester ports + controller ports)
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int MAX_HOLD     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    sdram_arbiter_if.slave  io_bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int STRV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    localparam logic [STRV_W-1:0] STRV_MAX = STRV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // r_grant doubles as the "last granted port" used by the hold rule
    logic [1:0]          r_grant;
    logic                r_rr_next;      // 0: prefer port 1, 1: prefer port 2
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [STRV_W-1:0]   r_starve_cnt;

    logic                r_ctrl_we;
    logic [ADDR_W-1:0]   r_ctrl_addr;
    logic [DATA_W-1:0]   r_ctrl_wdata;
    logic [2:0]          r_rvalid;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_arb;
    logic                w_others;
    logic                w_req_last;
    logic                w_hold;
    logic                w_starved;
    logic [1:0]          w_sel;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [2:0]          w_grant_oh;

    assign w_grant_oh = 3'(3'b001 << r_grant);
    assign w_arb      = (r_state == S_IDLE) && (|io_bus.req);

    // Arbitration: hold, then starvation skip, then video, then CPU/GPU RR
    always_comb begin
        w_others   = io_bus.req[1] | io_bus.req[2];
        w_req_last = 1'b0;
        case (r_grant)
            2'd0:    w_req_last = io_bus.req[0];
            2'd1:    w_req_last = io_bus.req[1];
            2'd2:    w_req_last = io_bus.req[2];
            default: w_req_last = 1'b0;
        endcase
        // The counter never passes HOLD_MAX, so != behaves as <
        w_hold    = w_req_last && (r_hold_cnt != HOLD_MAX);
        w_starved = (r_starve_cnt == STRV_MAX) && w_others;

        if (w_hold) begin
            w_sel = r_grant;
        end else if (io_bus.req[0] && !w_starved) begin
            w_sel = 2'd0;
        end else if (io_bus.req[1] && io_bus.req[2]) begin
            w_sel = r_rr_next ? 2'd2 : 2'd1;
        end else if (io_bus.req[1]) begin
            w_sel = 2'd1;
        end else begin
            w_sel = 2'd2;
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        case (w_sel)
            2'd0: begin
                w_sel_we    = io_bus.we[0];
                w_sel_addr  = io_bus.addr[0 +: ADDR_W];
                w_sel_wdata = io_bus.wdata[0 +: DATA_W];
            end
            2'd1: begin
                w_sel_we    = io_bus.we[1];
                w_sel_addr  = io_bus.addr[ADDR_W +: ADDR_W];
                w_sel_wdata = io_bus.wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                w_sel_we    = io_bus.we[2];
                w_sel_addr  = io_bus.addr[2*ADDR_W +: ADDR_W];
                w_sel_wdata = io_bus.wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        io_bus.ctrl_req = 1'b0;
        io_bus.ack      = '0;
        case (r_state)
            S_IDLE: begin
                if (|io_bus.req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                io_bus.ctrl_req = 1'b1;
                if (io_bus.ctrl_ready) begin
                    io_bus.ack  = w_grant_oh;
                    w_state_nxt = r_ctrl_we ? S_IDLE : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (io_bus.ctrl_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Controller fields are captured at grant time so they cannot move while
    // the request is being backpressured, even if a requester misbehaves.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant      <= '0;
            r_rr_next    <= 1'b0;
            r_hold_cnt   <= '0;
            r_starve_cnt <= '0;
            r_ctrl_we    <= 1'b0;
            r_ctrl_addr  <= '0;
            r_ctrl_wdata <= '0;
            r_rvalid     <= '0;
            r_rdata      <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_arb) begin
                r_grant      <= w_sel;
                r_ctrl_we    <= w_sel_we;
                r_ctrl_addr  <= w_sel_addr;
                r_ctrl_wdata <= w_sel_wdata;
                r_hold_cnt   <= w_hold ? r_hold_cnt + 1'b1 : '0;
                if (w_sel == 2'd0) begin
                    if (!w_others) begin
                        r_starve_cnt <= '0;
                    end else if (r_starve_cnt != STRV_MAX) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end else begin
                    r_starve_cnt <= '0;
                    r_rr_next    <= (w_sel == 2'd1);
                end
            end
            if ((r_state == S_WAIT_RD) && io_bus.ctrl_rvalid) begin
                r_rvalid <= w_grant_oh;
                r_rdata  <= io_bus.ctrl_rdata;
            end
        end
    end

    assign io_bus.ctrl_we    = r_ctrl_we;
    assign io_bus.ctrl_addr  = r_ctrl_addr;
    assign io_bus.ctrl_wdata = r_ctrl_wdata;
    assign io_bus.rvalid     = r_rvalid;
    assign io_bus.rdata      = r_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. DUT A: MAX_HOLD=1, STARVE_LIMIT=8.
// DUT B: MAX_HOLD=4, STARVE_LIMIT=8. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) ifa ();
    sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) ifb ();

    sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .MAX_HOLD(1), .STARVE_LIMIT(8)) dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (ifa.slave)
    );

    sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .MAX_HOLD(4), .STARVE_LIMIT(8)) dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (ifb.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] got [0:31];
    int         got_n;

    logic [63:0] obs;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        ifa.req = '0; ifb.req = '0;
        ifa.ctrl_rvalid = 1'b0; ifb.ctrl_rvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Records ack values of DUT A until n acks are seen or budget runs out
    task automatic collect_acks_a(input int n, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < n; c++) begin
            @(negedge clk);
            if (ifa.ack != 3'b000) begin
                got[got_n] = ifa.ack;
                got_n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {ifa.ack, ifa.rvalid, ifa.rdata, ifa.ctrl_req, ifa.ctrl_we, ifa.ctrl_addr, ifa.ctrl_wdata};
        vectors++;
        if (obs !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_a outputs got %h want 0", obs);
        end
        obs = {ifb.ack, ifb.rvalid, ifb.rdata, ifb.ctrl_req, ifb.ctrl_we, ifb.ctrl_addr, ifb.ctrl_wdata};
        vectors++;
        if (obs !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_b outputs got %h want 0", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        logic [2:0] exp_ack, exp_rv;
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            ifa.we = 3'b000;
            ifa.addr = '0;
            ifa.addr[24 +: 24] = 24'h000100;
            ifa.req = (t <= 1) ? 3'b010 : 3'b000;
            ifa.ctrl_rvalid = (t == 4);
            ifa.ctrl_rdata  = (t == 4) ? 16'hBEEF : 16'h0000;
            @(negedge clk);
            exp_ack = (t == 1) ? 3'b010 : 3'b000;
            exp_rv  = (t == 5) ? 3'b010 : 3'b000;
            vectors++;
            if (ifa.ack !== exp_ack) begin
                miscompares++;
                $display("FAIL rd_ack t=%0d got %b want %b", t, ifa.ack, exp_ack);
            end
            vectors++;
            if (ifa.rvalid !== exp_rv) begin
                miscompares++;
                $display("FAIL rd_rvalid t=%0d got %b want %b", t, ifa.rvalid, exp_rv);
            end
            if (t == 1) begin
                vectors++;
                if ({ifa.ctrl_req, ifa.ctrl_we, ifa.ctrl_addr} !== {1'b1, 1'b0, 24'h000100}) begin
                    miscompares++;
                    $display("FAIL rd_ctrl got req=%b we=%b addr=%h want 1 0 000100",
                             ifa.ctrl_req, ifa.ctrl_we, ifa.ctrl_addr);
                end
            end
            if (t == 5) begin
                vectors++;
                if (ifa.rdata !== 16'hBEEF) begin
                    miscompares++;
                    $display("FAIL rd_rdata got %h want beef", ifa.rdata);
                end
            end
        end
        ifa.ctrl_rvalid = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        apply_reset();
        ifa.we  = 3'b110;
        ifa.req = 3'b110;
        collect_acks_a(6, 40);
        @(posedge clk); #1;
        ifa.req = 3'b000;
        vectors++;
        if (got_n !== 6) begin
            miscompares++;
            $display("FAIL rr_count got %0d want 6", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            exp = (i % 2 == 0) ? 3'b010 : 3'b100;
            vectors++;
            if (got[i] !== exp) begin
                miscompares++;
                $display("FAIL rr_grant #%0d got %b want %b", i, got[i], exp);
            end
        end
    endtask

    task automatic test_starvation();
        logic [2:0] exp;
        apply_reset();
        ifa.we  = 3'b011;
        ifa.req = 3'b011;
        collect_acks_a(18, 80);
        @(posedge clk); #1;
        ifa.req = 3'b000;
        vectors++;
        if (got_n !== 18) begin
            miscompares++;
            $display("FAIL starve_count got %0d want 18", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            exp = (i == 8 || i == 17) ? 3'b010 : 3'b001;
            vectors++;
            if (got[i] !== exp) begin
                miscompares++;
                $display("FAIL starve_grant #%0d got %b want %b", i, got[i], exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0] exp;
        apply_reset();
        ifb.ctrl_ready = 1'b1;
        ifb.we  = 3'b101;
        ifb.req = 3'b100;
        got_n = 0;
        for (int c = 0; c < 60 && got_n < 6; c++) begin
            @(negedge clk);
            if (ifb.ack != 3'b000) begin
                got[got_n] = ifb.ack;
                got_n++;
            end
            @(posedge clk); #1;
            if (got_n >= 1) ifb.req = 3'b101;
        end
        ifb.req = 3'b000;
        vectors++;
        if (got_n !== 6) begin
            miscompares++;
            $display("FAIL hold_count got %0d want 6", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            exp = (i < 4) ? 3'b100 : 3'b001;
            vectors++;
            if (got[i] !== exp) begin
                miscompares++;
                $display("FAIL hold_grant #%0d got %b want %b", i, got[i], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_ack;
        logic       exp_req;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                ifa.we = 3'b001;
                ifa.addr = '0;
                ifa.wdata = '0;
                ifa.addr[0 +: 24]  = 24'h123456;
                ifa.wdata[0 +: 16] = 16'hA5A5;
                ifa.req = 3'b001;
            end
            if (t == 3) begin
                ifa.addr[24 +: 24]  = 24'hFFFFFF;
                ifa.wdata[16 +: 16] = 16'h5A5A;
            end
            if (t == 7) ifa.req = 3'b000;
            ifa.ctrl_ready = (t >= 6);
            @(negedge clk);
            exp_ack = (t == 6) ? 3'b001 : 3'b000;
            exp_req = (t >= 1 && t <= 6);
            vectors++;
            if ({ifa.ctrl_req, ifa.ack} !== {exp_req, exp_ack}) begin
                miscompares++;
                $display("FAIL bp_handshake t=%0d got req=%b ack=%b want req=%b ack=%b",
                         t, ifa.ctrl_req, ifa.ack, exp_req, exp_ack);
            end
            if (exp_req) begin
                vectors++;
                if ({ifa.ctrl_we, ifa.ctrl_addr, ifa.ctrl_wdata} !== {1'b1, 24'h123456, 16'hA5A5}) begin
                    miscompares++;
                    $display("FAIL bp_fields t=%0d got we=%b addr=%h wdata=%h want 1 123456 a5a5",
                             t, ifa.ctrl_we, ifa.ctrl_addr, ifa.ctrl_wdata);
                end
            end
        end
        ifa.ctrl_ready = 1'b1;
    endtask

    task automatic test_reset_wait_rd();
        for (int t = 0; t < 9; t++) begin
            @(posedge clk); #1;
            case (t)
                0: begin
                    ifa.we = 3'b000;
                    ifa.addr = '0;
                    ifa.addr[24 +: 24] = 24'h0000AA;
                    ifa.req = 3'b010;
                end
                2: ifa.req = 3'b000;
                3: rst = 1'b1;
                4: begin
                    rst = 1'b0;
                    ifa.ctrl_rvalid = 1'b1;
                    ifa.ctrl_rdata  = 16'h1234;
                end
                5: ifa.ctrl_rvalid = 1'b0;
                6: begin
                    ifa.we  = 3'b110;
                    ifa.req = 3'b110;
                end
                8: ifa.req = 3'b000;
                default: ;
            endcase
            @(negedge clk);
            if (t == 1) begin
                vectors++;
                if (ifa.ack !== 3'b010) begin
                    miscompares++;
                    $display("FAIL rst_rd_ack got %b want 010", ifa.ack);
                end
            end
            if (t == 4 || t == 5) begin
                obs = {ifa.ack, ifa.rvalid, ifa.rdata, ifa.ctrl_req, ifa.ctrl_we, ifa.ctrl_addr, ifa.ctrl_wdata};
                vectors++;
                if (obs !== 64'h0) begin
                    miscompares++;
                    $display("FAIL rst_rd_outputs t=%0d got %h want 0", t, obs);
                end
            end
            if (t == 7) begin
                vectors++;
                if ({ifa.ctrl_req, ifa.ack} !== {1'b1, 3'b010}) begin
                    miscompares++;
                    $display("FAIL rst_rd_next got req=%b ack=%b want 1 010", ifa.ctrl_req, ifa.ack);
                end
            end
            if (t == 8) begin
                vectors++;
                if (ifa.ack !== 3'b000) begin
                    miscompares++;
                    $display("FAIL rst_rd_idle got ack=%b want 000", ifa.ack);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.req = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0;
        ifa.ctrl_ready = 1'b1; ifa.ctrl_rvalid = 1'b0; ifa.ctrl_rdata = '0;
        ifb.req = '0; ifb.we = '0; ifb.addr = '0; ifb.wdata = '0;
        ifb.ctrl_ready = 1'b1; ifb.ctrl_rvalid = 1'b0; ifb.ctrl_rdata = '0;

        test_reset();
        test_single_read();
        test_round_robin();
        test_starvation();
        test_hold();
        test_backpressure();
        test_reset_wait_rd();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port arbiter that shares the single SDRAM controller request interface between video scanout (port 0), CPU (port 1) and GPU (port 2). It sits between the requesters and the SDRAM controller, and holds one transaction in flight at a time. It returns read data to the port that issued the request. Video has fixed priority, bounded by a starvation limit. CPU and GPU alternate round-robin. A hold counter allows short same-port runs for scanout bursts.

## Interface
- ADDR_W, 24, word address width (16-bit words)
- DATA_W, 16, data width
- MAX_HOLD, 4, max consecutive grants to one port while its req stays high
- STARVE_LIMIT, 8, max consecutive port-0 grants while port 1 or 2 is waiting
- clk  in  1  system clock; everything on rising edge
- reset  in  1  synchronous, active-high
- req  in  3  per-port request; held with we/addr/wdata stable until ack
- we  in  3  per-port write enable (1 = write, 0 = read)
- addr  in  3*ADDR_W  port n at [n*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  port n at [n*DATA_W +: DATA_W]
- ack  out  3  one-cycle pulse: port's request accepted by controller
- rvalid  out  3  one-cycle pulse: rdata valid for that port
- rdata  out  DATA_W  shared read data, qualified by rvalid
- ctrl_req  out  1  request to SDRAM controller
- ctrl_we, ctrl_addr, ctrl_wdata  out  1/ADDR_W/DATA_W  muxed fields of granted port
- ctrl_ready  in  1  controller accepts when ctrl_req & ctrl_ready
- ctrl_rvalid  in  1  read data valid from controller
- ctrl_rdata  in  DATA_W  read data from controller

## Operation
- States:
  - IDLE: arbitrate when any req is high; register grant (2 bits), go to ISSUE. Otherwise stay.
  - ISSUE: drive ctrl_req=1 and the muxed fields from the grant register. On ctrl_ready, assert ack[grant] combinationally that cycle. A write then goes to IDLE; a read goes to WAIT_RD.
  - WAIT_RD: on ctrl_rvalid, register ctrl_rdata into rdata and pulse rvalid[grant] next cycle, then go to IDLE.
- Arbitration, evaluated in IDLE in this order:
  1. Hold: if req[last] is high and hold_cnt < MAX_HOLD-1, re-grant last and increment hold_cnt. Otherwise hold_cnt = 0 on any grant to a different port, or after a forced switch.
  2. Starvation: if starve_cnt == STARVE_LIMIT and req[1]|req[2], skip port 0.
  3. If req[0] is high, grant port 0.
  4. Otherwise grant between ports 1 and 2 round-robin. rr_next points to the preferred port and flips to the other port after each grant to port 1 or 2. Take the sole requester if only one is requesting.
- starve_cnt:
  - increments on a port-0 grant while req[1]|req[2] is high
  - clears on any grant to port 1 or 2, or a port-0 grant with no others waiting
  - saturates at STARVE_LIMIT
- ctrl fields change only in IDLE→ISSUE. They stay stable while ctrl_req=1 and ctrl_ready=0.
- A requester dropping req before ack is illegal. The arbiter still completes the granted transaction and pulses ack.
- ctrl_rvalid outside WAIT_RD is ignored.
- Reset, including mid-transaction: next state IDLE. The in-flight read is discarded with no rvalid. The SDRAM controller shares the same reset.
- Reset values:
  - all outputs 0
  - grant = 0, last = 0
  - rr_next = 1
  - hold_cnt = 0, starve_cnt = 0

## Timing
- Latency: req sampled high at edge k (IDLE) → ctrl_req high in cycle k+1. With ctrl_ready=1, ack is also in k+1.
- Write throughput: 2 cycles per transaction minimum (IDLE, ISSUE).
- Read: ctrl_rvalid in cycle m → rvalid/rdata in cycle m+1. Next arbitration happens in cycle m+1 (IDLE).
- ack and ctrl_req & ctrl_ready are coincident. ack never asserts in IDLE or WAIT_RD.
- At most one bit of ack and one bit of rvalid is high per cycle.
- Simultaneous requests in the same IDLE cycle are resolved purely by the ordered rules above. There are no ties.

## Test plan
- Single reads:
  - Stimulus: port 1 reads addr 0x000100, controller returns 0xBEEF 3 cycles after accept.
  - Required: ack[1] in the cycle after req; rvalid[1] with rdata=0xBEEF one cycle after ctrl_rvalid; ports 0 and 2 see no pulses.
- Round-robin:
  - Stimulus: ports 1 and 2 each continuously write, ctrl_ready=1, MAX_HOLD=1.
  - Required: grants alternate 1,2,1,2…; first grant goes to port 1 after reset.
- Video priority and starvation limit:
  - Stimulus: ports 0 and 1 continuously request, MAX_HOLD=1, STARVE_LIMIT=8.
  - Required: exactly 8 port-0 grants, then 1 port-1 grant, repeating.
- Hold:
  - Stimulus: port 2 requests continuously, then port 0 starts requesting, MAX_HOLD=4.
  - Required: port 2 keeps at most 4 consecutive grants, then port 0 is granted.
- Backpressure:
  - Stimulus: ctrl_ready low for 5 cycles during ISSUE.
  - Required: ctrl_addr/ctrl_we/ctrl_wdata stable throughout; single ack on the first ready cycle.
- Reset in WAIT_RD:
  - Stimulus: assert reset one cycle, then a late ctrl_rvalid arrives.
  - Required: all outputs 0 after the edge; no rvalid; next request is served normally with rr_next=1.
